// File: rtl/udp_rx_frame_sched.sv
// udp_rx_frame_sched
// Triple-buffer frame scheduler between a UDP video receiver and a frame
// reader. Incoming pixel words are written into one of three frame buffers.
// A completed frame becomes the single READY frame and replaces any older
// READY frame, which is counted as skipped. A reader takes the READY frame
// with a rd_req/rd_ack handshake and hands it back with rd_release.
//
// Ports
//   app_rx_clk, rstn        clock, asynchronous active-low reset
//   enable                  1 = start new frames on vid_vs
//   vid_vs/vid_de/vid_data  frame-start pulse, word valid, 16-bit pixel word
//   wr_en/wr_addr/wr_data   frame-memory write port (one cycle after vid_de)
//   frame_done, frame_err   pulses: frame complete / short frame aborted
//   rd_req, rd_ack          reader request level, one-cycle grant pulse
//   rd_base, rd_busy        granted buffer base address, reader holds buffer
//   rd_release              reader hands its buffer back
//   err_cnt, skip_cnt       saturating aborted / superseded frame counters
module udp_rx_frame_sched #(
  parameter int          FRAME_WORDS = 786432,
  parameter logic [27:0] BASE_ADDR   = 28'h0000000,
  parameter logic [27:0] BUF_STRIDE  = 28'h0100000
) (
  input  logic        app_rx_clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        vid_vs,
  input  logic        vid_de,
  input  logic [15:0] vid_data,
  output logic        wr_en,
  output logic [27:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_done,
  output logic        frame_err,
  input  logic        rd_req,
  output logic        rd_ack,
  output logic [27:0] rd_base,
  output logic        rd_busy,
  input  logic        rd_release,
  output logic [15:0] err_cnt,
  output logic [15:0] skip_cnt
);

  localparam logic [1:0] T_FREE    = 2'd0;
  localparam logic [1:0] T_WRITING = 2'd1;
  localparam logic [1:0] T_READY   = 2'd2;
  localparam logic [1:0] T_READING = 2'd3;

  localparam logic [0:0] W_IDLE   = 1'b0;
  localparam logic [0:0] W_ACTIVE = 1'b1;

  localparam logic [23:0] LAST_WCNT = 24'(FRAME_WORDS - 1);

  logic [1:0]  tag_q [0:2];
  logic [1:0]  tag_d [0:2];
  logic [0:0]  state_q, state_d;
  logic [1:0]  cur_q, cur_d;
  logic [23:0] wcnt_q, wcnt_d;
  logic [1:0]  rd_idx_q;
  logic        done_p0;

  logic        wr_vld;
  logic        done_set;
  logic        err_set;
  logic        skip_set;
  logic        grant;
  logic        rel;
  logic        rdy_found;
  logic [1:0]  rdy_idx;
  logic        start;
  logic        abort;
  logic [2:0]  free_mask;
  logic [1:0]  alloc_idx;

  function automatic logic [27:0] base_of(input logic [1:0] idx);
    case (idx)
      2'd1:    base_of = BASE_ADDR + BUF_STRIDE;
      2'd2:    base_of = BASE_ADDR + (BUF_STRIDE << 1);
      default: base_of = BASE_ADDR;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    tag_d     = tag_q;
    state_d   = state_q;
    cur_d     = cur_q;
    wcnt_d    = wcnt_q;
    wr_vld    = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    skip_set  = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    rdy_found = 1'b0;
    rdy_idx   = 2'd0;
    free_mask = 3'b000;
    alloc_idx = 2'd0;

    // Grant decisions look only at the tags as they stood at the start of
    // the cycle, so a frame completing now is not grantable until next cycle.
    for (int i = 0; i < 3; i++) begin
      if (tag_q[i] == T_READY) begin
        rdy_found = 1'b1;
        rdy_idx   = 2'(i);
      end
    end
    grant = rd_req && !rd_busy && rdy_found;
    rel   = rd_release && rd_busy;

    if (rel)   tag_d[rd_idx_q] = T_FREE;
    if (grant) tag_d[rdy_idx]  = T_READING;

    if (state_q == W_IDLE) begin
      start = vid_vs && enable;
    end else if (vid_vs) begin
      // Short frame: drop it, optionally restart in the same cycle.
      abort         = 1'b1;
      err_set       = 1'b1;
      tag_d[cur_q]  = T_FREE;
      state_d       = W_IDLE;
      start         = enable;
    end else if (vid_de) begin
      wr_vld = 1'b1;
      wcnt_d = wcnt_q + 24'd1;
      if (wcnt_q == LAST_WCNT) begin
        tag_d[cur_q] = T_READY;
        done_set     = 1'b1;
        state_d      = W_IDLE;
        // The older READY frame is superseded unless the reader takes it now.
        for (int i = 0; i < 3; i++) begin
          if ((2'(i) != cur_q) && (tag_q[i] == T_READY) &&
              !(grant && (rdy_idx == 2'(i)))) begin
            tag_d[i] = T_FREE;
            skip_set = 1'b1;
          end
        end
      end
    end

    if (start) begin
      // Allocation sees pre-update tags, except that an aborted buffer is
      // immediately reusable for the frame that aborted it.
      for (int i = 0; i < 3; i++) begin
        free_mask[i] = (tag_q[i] == T_FREE) || (abort && (2'(i) == cur_q));
      end
      for (int i = 2; i >= 0; i--) begin
        if (free_mask[i]) alloc_idx = 2'(i);
      end
      tag_d[alloc_idx] = T_WRITING;
      cur_d            = alloc_idx;
      wcnt_d           = 24'd0;
      state_d          = W_ACTIVE;
    end
  end

  // Stage p0: buffer tags, writer state, registered write port and strobes
  always_ff @(posedge app_rx_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) tag_q[i] <= T_FREE;
      state_q    <= W_IDLE;
      cur_q      <= 2'd0;
      wcnt_q     <= 24'd0;
      wr_en      <= 1'b0;
      wr_addr    <= 28'd0;
      wr_data    <= 16'd0;
      done_p0    <= 1'b0;
      frame_err  <= 1'b0;
      rd_ack     <= 1'b0;
      rd_busy    <= 1'b0;
      rd_base    <= 28'd0;
      rd_idx_q   <= 2'd0;
      err_cnt    <= 16'd0;
      skip_cnt   <= 16'd0;
    end else begin
      tag_q     <= tag_d;
      state_q   <= state_d;
      cur_q     <= cur_d;
      wcnt_q    <= wcnt_d;
      wr_en     <= wr_vld;
      if (wr_vld) begin
        wr_addr <= base_of(cur_q) + {4'd0, wcnt_q};
        wr_data <= vid_data;
      end
      done_p0   <= done_set;
      frame_err <= err_set;
      rd_ack    <= grant;
      if (grant) begin
        rd_busy  <= 1'b1;
        rd_base  <= base_of(rdy_idx);
        rd_idx_q <= rdy_idx;
      end else if (rel) begin
        rd_busy  <= 1'b0;
      end
      if (err_set)  err_cnt  <= sat_inc(err_cnt);
      if (skip_set) skip_cnt <= sat_inc(skip_cnt);
    end
  end

  // Stage p1: frame_done trails the READY transition by one cycle
  always_ff @(posedge app_rx_clk or negedge rstn) begin
    if (!rstn) frame_done <= 1'b0;
    else       frame_done <= done_p0;
  end

endmodule

// File: tb/tb_udp_rx_frame_sched.sv
// Testbench for udp_rx_frame_sched with FRAME_WORDS=4, BASE_ADDR=0,
// BUF_STRIDE=0x100. A frame-level reference model tracks buffer ownership and
// predicts every output each cycle; directed scenarios add literal checks.
module tb_udp_rx_frame_sched;

  logic        app_rx_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        vid_vs = 1'b0;
  logic        vid_de = 1'b0;
  logic [15:0] vid_data = 16'd0;
  logic        wr_en;
  logic [27:0] wr_addr;
  logic [15:0] wr_data;
  logic        frame_done;
  logic        frame_err;
  logic        rd_req = 1'b0;
  logic        rd_ack;
  logic [27:0] rd_base;
  logic        rd_busy;
  logic        rd_release = 1'b0;
  logic [15:0] err_cnt;
  logic [15:0] skip_cnt;

  udp_rx_frame_sched #(
    .FRAME_WORDS(4),
    .BASE_ADDR  (28'h0),
    .BUF_STRIDE (28'h100)
  ) dut (
    .app_rx_clk(app_rx_clk),
    .rstn      (rstn),
    .enable    (enable),
    .vid_vs    (vid_vs),
    .vid_de    (vid_de),
    .vid_data  (vid_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .rd_req    (rd_req),
    .rd_ack    (rd_ack),
    .rd_base   (rd_base),
    .rd_busy   (rd_busy),
    .rd_release(rd_release),
    .err_cnt   (err_cnt),
    .skip_cnt  (skip_cnt)
  );

  always #5 app_rx_clk = ~app_rx_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: buffer owners 0=free 1=filling 2=ready 3=with reader
  int m_tag [3] = '{0, 0, 0};
  bit m_act = 0;
  int m_cur = 0, m_cnt = 0;
  bit m_busy = 0;
  int m_rbuf = 0, m_base = 0;
  bit e_wr_en = 0, e_done = 0, done_pend = 0, e_err = 0, e_ack = 0;
  int e_addr = 0, e_data = 0, e_err_cnt = 0, e_skip_cnt = 0;
  int old_t [3];
  int g, a;

  always @(posedge app_rx_clk or negedge rstn) begin
    if (!rstn) begin
      m_tag = '{0, 0, 0};
      m_act = 0; m_cur = 0; m_cnt = 0; m_busy = 0; m_rbuf = 0; m_base = 0;
      e_wr_en = 0; e_done = 0; done_pend = 0; e_err = 0; e_ack = 0;
      e_addr = 0; e_data = 0; e_err_cnt = 0; e_skip_cnt = 0;
    end else begin
      old_t = m_tag;
      e_wr_en = 0; e_err = 0; e_ack = 0;
      e_done = done_pend; done_pend = 0;
      g = -1;
      if (rd_req && !m_busy)
        for (int i = 0; i < 3; i++) if (g < 0 && old_t[i] == 2) g = i;
      if (rd_release && m_busy) begin m_tag[m_rbuf] = 0; m_busy = 0; end
      if (g >= 0) begin
        m_tag[g] = 3; m_busy = 1; m_rbuf = g; m_base = g * 256; e_ack = 1;
      end
      if (m_act && vid_vs) begin
        m_tag[m_cur] = 0; old_t[m_cur] = 0; m_act = 0; e_err = 1;
        if (e_err_cnt < 65535) e_err_cnt++;
      end else if (m_act && vid_de) begin
        e_wr_en = 1; e_addr = m_cur * 256 + m_cnt; e_data = int'(vid_data);
        m_cnt++;
        if (m_cnt == 4) begin
          m_tag[m_cur] = 2; done_pend = 1; m_act = 0;
          for (int j = 0; j < 3; j++)
            if (j != m_cur && old_t[j] == 2 && j != g) begin
              m_tag[j] = 0;
              if (e_skip_cnt < 65535) e_skip_cnt++;
            end
        end
      end
      if (!m_act && vid_vs && enable) begin
        a = -1;
        for (int i = 0; i < 3; i++) if (a < 0 && old_t[i] == 0) a = i;
        if (a >= 0) begin m_tag[a] = 1; m_cur = a; m_cnt = 0; m_act = 1; end
      end
    end
  end

  // Per-cycle comparison and write log
  typedef struct { logic [27:0] a; logic [15:0] d; } wr_t;
  wr_t wlog [$];
  int cyc = 0, last_wr_cyc = 0, done_cyc = 0;

  always @(posedge app_rx_clk) cyc++;

  always @(negedge app_rx_clk) begin
    chk("wr_en", 32'(wr_en), 32'(e_wr_en));
    if (e_wr_en) begin
      chk("wr_addr", 32'(wr_addr), 32'(e_addr));
      chk("wr_data", 32'(wr_data), 32'(e_data));
    end
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("frame_err", 32'(frame_err), 32'(e_err));
    chk("rd_ack", 32'(rd_ack), 32'(e_ack));
    chk("rd_busy", 32'(rd_busy), 32'(m_busy));
    chk("rd_base", 32'(rd_base), 32'(m_base));
    chk("err_cnt", 32'(err_cnt), 32'(e_err_cnt));
    chk("skip_cnt", 32'(skip_cnt), 32'(e_skip_cnt));
    if (wr_en) begin
      wlog.push_back('{wr_addr, wr_data});
      last_wr_cyc = cyc;
    end
    if (frame_done) done_cyc = cyc;
  end

  task automatic tick();
    @(posedge app_rx_clk);
    #1;
  endtask

  task automatic send_vs();
    vid_vs = 1'b1; tick(); vid_vs = 1'b0;
  endtask

  task automatic send_de(input logic [15:0] d);
    vid_de = 1'b1; vid_data = d; tick(); vid_de = 1'b0;
  endtask

  task automatic do_frame(input logic [15:0] d0);
    send_vs();
    for (int i = 0; i < 4; i++) send_de(d0 + 16'(i));
    tick(); tick();
  endtask

  task automatic grab(input logic [27:0] exp_base);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    chk("grab_ack", 32'(rd_ack), 32'd1);
    chk("grab_base", 32'(rd_base), 32'(exp_base));
    tick();
    chk("grab_ack_pulse", 32'(rd_ack), 32'd0);
    chk("grab_busy", 32'(rd_busy), 32'd1);
  endtask

  task automatic release_buf();
    rd_release = 1'b1; tick(); rd_release = 1'b0;
    chk("release_busy", 32'(rd_busy), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_rd_ack"}, 32'(rd_ack), 32'd0);
    chk({tag, "_rd_busy"}, 32'(rd_busy), 32'd0);
    chk({tag, "_rd_base"}, 32'(rd_base), 32'd0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    chk({tag, "_skip_cnt"}, 32'(skip_cnt), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk_reset_outputs("reset");
    rstn = 1'b1;
    tick();
    enable = 1'b1;

    // Normal frame into buffer 0
    wlog.delete();
    do_frame(16'd1);
    chk("nf_count", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("nf_addr", 32'(wlog[i].a), 32'(i));
      chk("nf_data", 32'(wlog[i].d), 32'(i + 1));
    end
    chk("nf_done_lat", 32'(done_cyc - last_wr_cyc), 32'd1);
    chk("nf_model_buf0_ready", 32'(m_tag[0]), 32'd2);

    // Read handshake, then the next frame reuses buffer 0
    grab(28'h000);
    release_buf();
    wlog.delete();
    do_frame(16'h10);
    chk("rh_next_addr", 32'(wlog.size() > 0 ? wlog[0].a : 28'hFFFFFFF), 32'h000);

    // Short frame aborted, restart lands in buffer 0 again
    grab(28'h000);
    release_buf();
    wlog.delete();
    send_vs();
    send_de(16'h21);
    send_de(16'h22);
    send_vs();
    chk("sf_frame_err", 32'(frame_err), 32'd1);
    chk("sf_err_cnt", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 4; i++) send_de(16'h31 + 16'(i));
    tick(); tick();
    chk("sf_count", 32'(wlog.size()), 32'd6);
    chk("sf_restart_addr", 32'(wlog.size() > 2 ? wlog[2].a : 28'hFFFFFFF), 32'h000);
    chk("sf_model_err", 32'(e_err_cnt), 32'd1);

    // Supersede: two frames with no read in between
    grab(28'h000);
    release_buf();
    do_frame(16'h40);
    do_frame(16'h50);
    chk("ss_skip_cnt", 32'(skip_cnt), 32'd1);
    chk("ss_model_buf1_ready", 32'(m_tag[1]), 32'd2);
    chk("ss_model_buf0_free", 32'(m_tag[0]), 32'd0);
    grab(28'h100);
    release_buf();

    // Same-cycle race: 4th word into buffer 1 with rd_req while buffer 0 READY
    do_frame(16'h60);
    send_vs();
    for (int i = 0; i < 3; i++) send_de(16'h70 + 16'(i));
    vid_de = 1'b1; vid_data = 16'h73; rd_req = 1'b1;
    tick();
    vid_de = 1'b0; rd_req = 1'b0;
    chk("race_ack", 32'(rd_ack), 32'd1);
    chk("race_base", 32'(rd_base), 32'h000);
    chk("race_skip", 32'(skip_cnt), 32'd1);
    chk("race_model_buf1_ready", 32'(m_tag[1]), 32'd2);
    tick(); tick();
    release_buf();
    grab(28'h100);

    // Reset mid-frame while the reader holds a buffer
    send_vs();
    send_de(16'h90);
    send_de(16'h91);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    tick(); tick();
    rstn = 1'b1;
    tick();
    wlog.delete();
    do_frame(16'h80);
    chk("pr_count", 32'(wlog.size()), 32'd4);
    chk("pr_addr", 32'(wlog.size() > 0 ? wlog[0].a : 28'hFFFFFFF), 32'h000);

    // vid_vs with enable low starts nothing
    enable = 1'b0;
    send_vs();
    send_de(16'hAA);
    tick();
    chk("dis_no_write", 32'(wlog.size()), 32'd4);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_rx_frame_sched.md
UDP_RX_FRAME_SCHED -- requirements
Module: udp_rx_frame_sched

Interface
REQ-001 SHALL expose parameters (name, default, meaning):
- FRAME_WORDS, 786432, 16-bit words per complete frame (1024x768).
- BASE_ADDR, 28'h0000000, base word address of buffer 0.
- BUF_STRIDE, 28'h0100000, word-address distance between buffers.
REQ-002 SHALL expose ports (name direction width meaning):
- app_rx_clk  in  1  sole clock, 125 MHz.
- rstn  in  1  reset.
- enable  in  1  level; 1 = accept new frames.
- vid_vs  in  1  one-cycle frame-start pulse from the UDP RX buffer.
- vid_de  in  1  pixel-word valid.
- vid_data  in  16  pixel word.
- wr_en  out  1  write strobe to frame memory.
- wr_addr  out  28  write word address.
- wr_data  out  16  write data.
- frame_done  out  1  pulse, frame fully written.
- frame_err  out  1  pulse, short frame aborted.
- rd_req  in  1  level, reader wants a frame.
- rd_ack  out  1  pulse, frame granted.
- rd_base  out  28  base address of granted frame, held until release.
- rd_busy  out  1  reader holds a buffer.
- rd_release  in  1  pulse, reader finished.
- err_cnt  out  16  aborted-frame count, saturating.
- skip_cnt  out  16  superseded-frame count, saturating.
REQ-003 SHALL use reset rstn, asynchronous, active-low; clock app_rx_clk.

Function
REQ-004 SHALL manage three buffers, base(i) = BASE_ADDR + i*BUF_STRIDE, each tagged FREE, WRITING, READY or READING.
REQ-005 SHALL run a writer FSM with states W_IDLE and W_ACTIVE and a 24-bit word counter wcnt.
REQ-006 W_IDLE + vid_vs + enable SHALL allocate the lowest-index FREE buffer, mark it WRITING, clear wcnt and enter W_ACTIVE.
REQ-007 Outside W_ACTIVE, vid_de SHALL be ignored; vid_vs with enable=0 SHALL be ignored.
REQ-008 In W_ACTIVE, each vid_de SHALL produce, on the next cycle, wr_en=1, wr_addr = base(cur)+wcnt and wr_data = vid_data, then increment wcnt.
REQ-009 When the FRAME_WORDS-th word is accepted:
- current buffer SHALL go READY the same cycle;
- any other READY buffer SHALL go FREE and skip_cnt SHALL increment;
- frame_done SHALL pulse the next cycle;
- FSM SHALL return to W_IDLE.
REQ-010 vid_vs in W_ACTIVE with wcnt < FRAME_WORDS (short frame) SHALL:
- return the current buffer to FREE;
- pulse frame_err and increment err_cnt;
- start the new frame per REQ-006 in the same cycle if enable=1, else go to W_IDLE.
REQ-011 Dropping enable SHALL NOT abort an active frame.
REQ-012 At most one buffer SHALL be READY, so a FREE buffer always exists at allocation.
REQ-013 Reader grant with rd_req=1, rd_busy=0 and a READY buffer: that buffer SHALL go READING, rd_base = its base, rd_ack SHALL pulse one cycle, and rd_busy=1 from the next cycle.
REQ-014 rd_release with rd_busy=1 SHALL set the READING buffer FREE and clear rd_busy the next cycle; rd_release with rd_busy=0 SHALL be ignored; rd_req with rd_busy=1 SHALL be ignored.
REQ-015 Grant and completion in the same cycle: the grant SHALL use pre-update tags. The granted buffer SHALL go READING, not FREE, and SHALL NOT count as skipped. The newly completed buffer SHALL become READY.
REQ-016 A buffer completing in cycle N SHALL be grantable no earlier than cycle N+1.
REQ-017 Release and allocation in the same cycle: allocation SHALL use pre-update tags.
REQ-018 err_cnt and skip_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-019 On rstn=0, all of the following SHALL hold and none SHALL be retained: every buffer FREE; writer W_IDLE; wcnt=0; wr_en=0, wr_addr=0, wr_data=0; frame_done=0, frame_err=0; rd_ack=0, rd_busy=0, rd_base=0; err_cnt=0, skip_cnt=0.
REQ-020 Reset mid-frame SHALL discard the partial frame and any READING grant.

Verification (FRAME_WORDS=4, BASE_ADDR=0, BUF_STRIDE=28'h100)
REQ-021 Bench scenarios:
- Normal frame: vs, 4x de (data 1..4) -> wr_addr 0,1,2,3 with data 1..4; frame_done 1 cycle after the 4th wr_en; buffer 0 READY.
- Read handshake: rd_req after that frame -> rd_ack pulse with rd_base=0, rd_busy=1; rd_release -> rd_busy=0; next frame writes at 0x000.
- Short frame: vs, 2x de, vs -> frame_err pulse, err_cnt=1; new frame writes at 0x000 again.
- Supersede: two complete frames, no read -> skip_cnt=1, buffer 1 READY; rd_req -> rd_base=0x100.
- Same-cycle race: buffer 0 READY, reader holds none, 4th word of frame into buffer 1 coincides with rd_req -> rd_base=0x000, skip_cnt unchanged, buffer 1 READY.
- Reset mid-frame with rd_busy=1: all outputs at reset values; first frame after reset writes at 0x000.
